fetch_unit: RTL and testbench

- Instruction fetch front end that feeds the Core's `code`/`PC` inputs.
- Owns the fetch PC, issues single-outstanding requests to instruction memory over a req/ack handshake, and buffers returned words with their PCs in a small prefetch FIFO.
- Presents words to the pipeline with a valid/ready handshake.
- Handles redirects (jump/branch) by flushing and refetching.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_unit.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and FSM state encoding for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned PC_W     = 24;
  localparam int unsigned INSN_W   = 32;
  localparam int unsigned PC_STEP  = 4;
  localparam logic [31:0] NOP_INSN = 32'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, insn} entries; flush overrides any same-cycle push/pop.
module fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 56
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_push_data,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [WIDTH-1:0]       o_head
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_do_pop  = i_pop && (r_count != '0);
  assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_count = r_count;
  assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: single-outstanding imem requests feeding a prefetch FIFO.
// Define FETCH_STATS_EN to add saturating fetch_count/flush_count outputs.
module fetch_unit #(
  parameter int unsigned     PC_W     = fetch_pkg::PC_W,
  parameter int unsigned     INSN_W   = fetch_pkg::INSN_W,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INSN_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              code_valid,
  output logic [INSN_W-1:0] code,
  output logic [PC_W-1:0]   code_pc,
  input  logic              code_ready
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]       fetch_count,
  output logic [15:0]       flush_count
`endif
);

  import fetch_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_t           r_state;
  logic                   r_req;
  logic [PC_W-1:0]        r_pc;
  logic [PC_W-1:0]        r_addr;
  logic [CW-1:0]          w_count;
  logic [PC_W+INSN_W-1:0] w_head;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_credit_after;
  logic [PC_W-1:0]        w_pc_next;

  assign w_push    = (r_state == REQ) && imem_ack && !redirect_valid;
  assign w_pop     = code_valid && code_ready;
  assign w_pc_next = r_pc + PC_W'(PC_STEP);

  // Only evaluated on an accepted REQ ack, so count+1 never exceeds DEPTH.
  assign w_credit_after = (w_count + CW'(1) - CW'(w_pop)) < FULL_CNT;

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (PC_W + INSN_W)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (reset),
    .i_push      (w_push),
    .i_push_data ({r_pc, imem_rdata}),
    .i_pop       (w_pop),
    .i_flush     (redirect_valid),
    .o_count     (w_count),
    .o_head      (w_head)
  );

  // r_addr tracks r_pc except in DRAIN, where the outstanding address must not move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_pc    <= RESET_PC;
      r_addr  <= RESET_PC;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (redirect_valid) begin
            r_pc    <= redirect_pc;
            r_addr  <= redirect_pc;
            r_state <= REQ;
            r_req   <= 1'b1;
          end else if (w_count < FULL_CNT) begin
            r_state <= REQ;
            r_req   <= 1'b1;
          end
        end
        REQ: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
            if (imem_ack) r_addr <= redirect_pc;
            else          r_state <= DRAIN;
          end else if (imem_ack) begin
            r_pc   <= w_pc_next;
            r_addr <= w_pc_next;
            if (!w_credit_after) begin
              r_state <= IDLE;
              r_req   <= 1'b0;
            end
          end
        end
        DRAIN: begin
          if (redirect_valid) r_pc <= redirect_pc;
          if (imem_ack) begin
            r_addr  <= redirect_valid ? redirect_pc : r_pc;
            r_state <= REQ;
          end
        end
        default: begin
          r_state <= IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req   = r_req;
  assign imem_addr  = r_addr;
  assign code_valid = (w_count != '0);
  assign code       = code_valid ? w_head[INSN_W-1:0] : INSN_W'(NOP_INSN);
  assign code_pc    = code_valid ? w_head[PC_W+INSN_W-1:INSN_W] : '0;

`ifdef FETCH_STATS_EN
  logic        w_ack;
  logic [31:0] r_fetch_count;
  logic [15:0] r_flush_count;

  assign w_ack = r_req && imem_ack;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_count <= '0;
      r_flush_count <= '0;
    end else begin
      if (w_ack && (r_fetch_count != '1)) r_fetch_count <= r_fetch_count + 32'd1;
      if (redirect_valid && (r_flush_count != '1)) r_flush_count <= r_flush_count + 16'd1;
    end
  end

  assign fetch_count = r_fetch_count;
  assign flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected {pc, insn} entries queued on each driven ack.
module tb_fetch_unit;

  localparam int unsigned PC_W   = 24;
  localparam int unsigned INSN_W = 32;
  localparam int unsigned DEPTH  = 4;

  logic              clk            = 1'b0;
  logic              reset          = 1'b0;
  logic              imem_ack       = 1'b0;
  logic [INSN_W-1:0] imem_rdata     = '0;
  logic              redirect_valid = 1'b0;
  logic [PC_W-1:0]   redirect_pc    = '0;
  logic              code_ready     = 1'b0;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic              code_valid;
  logic [INSN_W-1:0] code;
  logic [PC_W-1:0]   code_pc;
`ifdef FETCH_STATS_EN
  logic [31:0]       fetch_count;
  logic [15:0]       flush_count;
`endif

  logic [PC_W+INSN_W-1:0] sb[$];
  logic [PC_W-1:0]        exp_addr;
  int                     n_checks = 0;
  int                     n_fail   = 0;

  always #5 clk = ~clk;

  fetch_unit #(
    .PC_W     (PC_W),
    .INSN_W   (INSN_W),
    .DEPTH    (DEPTH),
    .RESET_PC (24'h0)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .code_valid     (code_valid),
    .code           (code),
    .code_pc        (code_pc),
    .code_ready     (code_ready)
`ifdef FETCH_STATS_EN
    ,
    .fetch_count    (fetch_count),
    .flush_count    (flush_count)
`endif
  );

  function automatic logic [INSN_W-1:0] pat(input logic [PC_W-1:0] a);
    return {a[7:0] ^ 8'hC3, a};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b0; redirect_valid = 1'b0; code_ready = 1'b0; imem_rdata = '0;
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", imem_req); end
    n_checks++; if (imem_addr !== 24'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 000000", imem_addr); end
    n_checks++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", code_valid); end
    n_checks++; if ({code_pc, code} !== '0) begin n_fail++; $display("FAIL reset_code: got %h expected 0", {code_pc, code}); end
  endtask

  task automatic test_stream();
    do_reset();
    imem_ack = 1'b1; code_ready = 1'b1; exp_addr = 24'h0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      n_checks++;
      if (code_valid !== (sb.size() != 0)) begin n_fail++; $display("FAIL stream_valid: cycle %0d got %b expected %b", c, code_valid, sb.size() != 0); end
      n_checks++;
      if (sb.size() != 0) begin
        if ({code_pc, code} !== sb[0]) begin n_fail++; $display("FAIL stream_head: got %h expected %h", {code_pc, code}, sb[0]); end
        void'(sb.pop_front());
      end else if ({code_pc, code} !== '0) begin n_fail++; $display("FAIL stream_nop: got %h expected 0", {code_pc, code}); end
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin n_fail++; $display("FAIL stream_addr: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, exp_addr); end
      imem_rdata = pat(imem_addr);
      sb.push_back({exp_addr, pat(exp_addr)});
      exp_addr += 24'd4;
    end
  endtask

  task automatic test_backpressure();
    logic exp_req;
    logic got;
    do_reset();
    imem_ack = 1'b1; code_ready = 1'b0; exp_addr = 24'h0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      exp_req = (c <= 4);
      n_checks++;
      if (code_valid !== (sb.size() != 0)) begin n_fail++; $display("FAIL bp_valid: cycle %0d got %b expected %b", c, code_valid, sb.size() != 0); end
      if (sb.size() != 0) begin
        n_checks++;
        if ({code_pc, code} !== sb[0]) begin n_fail++; $display("FAIL bp_head: got %h expected %h", {code_pc, code}, sb[0]); end
      end
      n_checks++;
      if (imem_req !== exp_req) begin n_fail++; $display("FAIL bp_req: cycle %0d got %b expected %b", c, imem_req, exp_req); end
      if (exp_req) begin
        n_checks++;
        if (imem_addr !== exp_addr) begin n_fail++; $display("FAIL bp_addr: got %h expected %h", imem_addr, exp_addr); end
        sb.push_back({exp_addr, pat(exp_addr)});
        exp_addr += 24'd4;
      end
      imem_rdata = pat(imem_addr);
    end
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      @(negedge clk);
      code_ready = 1'b1;
      if (sb.size() != 0) begin
        n_checks++;
        if (code_valid !== 1'b1 || {code_pc, code} !== sb[0]) begin n_fail++; $display("FAIL bp_drain_head: got v=%b %h expected %h", code_valid, {code_pc, code}, sb[0]); end
        void'(sb.pop_front());
      end
      if (imem_req === 1'b1) begin
        got = 1'b1;
        n_checks++;
        if (imem_addr !== 24'h10) begin n_fail++; $display("FAIL bp_resume_addr: got %h expected 000010", imem_addr); end
        sb.push_back({exp_addr, pat(exp_addr)});
        exp_addr += 24'd4;
        imem_rdata = pat(imem_addr);
      end
    end
    n_checks++;
    if (!got) begin n_fail++; $display("FAIL bp_resume_timeout: got req=0 expected req=1 within 6 cycles"); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (code_valid !== (sb.size() != 0)) begin n_fail++; $display("FAIL bp_run_valid: got %b expected %b", code_valid, sb.size() != 0); end
      if (sb.size() != 0) begin
        n_checks++;
        if ({code_pc, code} !== sb[0]) begin n_fail++; $display("FAIL bp_run_head: got %h expected %h", {code_pc, code}, sb[0]); end
        void'(sb.pop_front());
      end
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin n_fail++; $display("FAIL bp_run_addr: got req=%b addr=%h expected %h", imem_req, imem_addr, exp_addr); end
      sb.push_back({exp_addr, pat(exp_addr)});
      exp_addr += 24'd4;
      imem_rdata = pat(imem_addr);
    end
  endtask

  task automatic test_ack_delay();
    do_reset();
    code_ready = 1'b1; imem_ack = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 24'h0) begin n_fail++; $display("FAIL ackd_hold: cycle %0d got req=%b addr=%h expected req=1 addr=000000", c, imem_req, imem_addr); end
      n_checks++;
      if (code_valid !== 1'b0) begin n_fail++; $display("FAIL ackd_novalid: got %b expected 0", code_valid); end
    end
    imem_ack = 1'b1; imem_rdata = pat(24'h0);
    sb.push_back({24'h0, pat(24'h0)});
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++;
    if (code_valid !== 1'b1 || {code_pc, code} !== sb[0]) begin n_fail++; $display("FAIL ackd_push: got v=%b %h expected %h", code_valid, {code_pc, code}, sb[0]); end
    void'(sb.pop_front());
    n_checks++;
    if (imem_addr !== 24'h4) begin n_fail++; $display("FAIL ackd_next_addr: got %h expected 000004", imem_addr); end
    @(negedge clk);
    n_checks++;
    if (code_valid !== 1'b0) begin n_fail++; $display("FAIL ackd_single_push: got valid=%b expected 0", code_valid); end
  endtask

  task automatic test_redirect_drain();
    do_reset();
    code_ready = 1'b0;
    exp_addr = 24'h0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin n_fail++; $display("FAIL drain_pre_addr: got %h expected %h", imem_addr, exp_addr); end
      if (c < 3) begin
        imem_ack = 1'b1; imem_rdata = pat(exp_addr);
        sb.push_back({exp_addr, pat(exp_addr)});
        exp_addr += 24'd4;
      end
    end
    imem_ack = 1'b0; redirect_valid = 1'b1; redirect_pc = 24'h000100;
    sb.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 24'h8) begin n_fail++; $display("FAIL drain_hold: got req=%b addr=%h expected req=1 addr=000008", imem_req, imem_addr); end
    n_checks++;
    if (code_valid !== 1'b0 || {code_pc, code} !== '0) begin n_fail++; $display("FAIL drain_flush: got v=%b %h expected v=0 0", code_valid, {code_pc, code}); end
    imem_ack = 1'b1; imem_rdata = pat(24'h8);
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 24'h100) begin n_fail++; $display("FAIL drain_new_addr: got req=%b addr=%h expected 000100", imem_req, imem_addr); end
    n_checks++;
    if (code_valid !== 1'b0) begin n_fail++; $display("FAIL drain_discard: got valid=%b expected 0", code_valid); end
    imem_rdata = pat(24'h100);
    sb.push_back({24'h100, pat(24'h100)});
    @(negedge clk);
    imem_ack = 1'b0;
    n_checks++;
    if (code_valid !== 1'b1 || {code_pc, code} !== sb[0]) begin n_fail++; $display("FAIL drain_first_pc: got v=%b %h expected %h", code_valid, {code_pc, code}, sb[0]); end
  endtask

  task automatic test_redirect_full();
    do_reset();
    imem_ack = 1'b1; code_ready = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      imem_rdata = pat(imem_addr);
    end
    n_checks++;
    if (imem_req !== 1'b0 || code_valid !== 1'b1) begin n_fail++; $display("FAIL full_stall: got req=%b valid=%b expected req=0 valid=1", imem_req, code_valid); end
    redirect_valid = 1'b1; redirect_pc = 24'h000200; code_ready = 1'b1; imem_ack = 1'b1;
    sb.delete();
    @(negedge clk);
    redirect_valid = 1'b0;
    n_checks++;
    if (code_valid !== 1'b0 || {code_pc, code} !== '0) begin n_fail++; $display("FAIL full_flush: got v=%b %h expected v=0 0", code_valid, {code_pc, code}); end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 24'h200) begin n_fail++; $display("FAIL full_redirect_addr: got req=%b addr=%h expected 000200", imem_req, imem_addr); end
    imem_rdata = pat(24'h200);
    sb.push_back({24'h200, pat(24'h200)});
    @(negedge clk);
    n_checks++;
    if (code_valid !== 1'b1 || {code_pc, code} !== sb[0]) begin n_fail++; $display("FAIL full_refetch: got v=%b %h expected %h", code_valid, {code_pc, code}, sb[0]); end
    redirect_valid = 1'b1; redirect_pc = 24'h000300; imem_rdata = pat(imem_addr);
    sb.delete();
    @(negedge clk);
    redirect_valid = 1'b0; imem_ack = 1'b0;
    n_checks++;
    if (code_valid !== 1'b0 || {code_pc, code} !== '0) begin n_fail++; $display("FAIL ack_redirect_flush: got v=%b %h expected v=0 0", code_valid, {code_pc, code}); end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 24'h300) begin n_fail++; $display("FAIL ack_redirect_addr: got req=%b addr=%h expected 000300", imem_req, imem_addr); end
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    code_ready = 1'b1; imem_ack = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 24'hFFFFF8; imem_rdata = pat(imem_addr);
    exp_addr = 24'hFFFFF8;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      redirect_valid = 1'b0;
      n_checks++;
      if (code_valid !== (sb.size() != 0)) begin n_fail++; $display("FAIL wrap_valid: got %b expected %b", code_valid, sb.size() != 0); end
      if (sb.size() != 0) begin
        n_checks++;
        if ({code_pc, code} !== sb[0]) begin n_fail++; $display("FAIL wrap_head: got %h expected %h", {code_pc, code}, sb[0]); end
        void'(sb.pop_front());
      end
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== exp_addr) begin n_fail++; $display("FAIL wrap_addr: got req=%b addr=%h expected %h", imem_req, imem_addr, exp_addr); end
      imem_rdata = pat(imem_addr);
      sb.push_back({exp_addr, pat(exp_addr)});
      exp_addr += 24'd4;
    end
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    n_checks++;
    if (imem_req !== 1'b0 || code_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_async: got req=%b valid=%b expected 0 0", imem_req, code_valid); end
    n_checks++;
    if (imem_addr !== 24'h0 || {code_pc, code} !== '0) begin n_fail++; $display("FAIL midreset_clear: got addr=%h code=%h expected 0 0", imem_addr, {code_pc, code}); end
    @(negedge clk);
    imem_rdata = pat(24'h444);
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 24'h0 || code_valid !== 1'b0) begin n_fail++; $display("FAIL post_reset_ignore: got req=%b addr=%h valid=%b expected 1 000000 0", imem_req, imem_addr, code_valid); end
    imem_ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_ack_delay();
    test_redirect_drain();
    test_redirect_full();
    test_wrap_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
